// File: rtl/dlfp_pkg.sv
// Shared DLfloat definitions: flag layout and encoding helpers.
package dlfp_pkg;

  // Flag vector bit positions, MSB first: {invalid, inexact, overflow, underflow, div_zero}
  localparam int FLG_INV  = 4;
  localparam int FLG_INEX = 3;
  localparam int FLG_OVF  = 2;
  localparam int FLG_UNF  = 1;
  localparam int FLG_DZ   = 0;

  typedef struct packed {
    logic inv;
    logic inex;
    logic ovf;
    logic unf;
    logic dz;
  } dlfp_flags_t;

  // Widest word the helpers handle; callers cast their W-bit words to/from this.
  localparam int DLFP_MAXW = 64;

  // All-ones word below the sign bit is the single NaN/Inf code.
  function automatic logic is_special(input logic [DLFP_MAXW-1:0] x, input int ew, input int mw);
    logic r;
    r = 1'b1;
    for (int i = 0; i < DLFP_MAXW; i++)
      if (i < ew + mw && !x[i]) r = 1'b0;
    return r;
  endfunction

  // A zero exponent field encodes zero (no subnormals).
  function automatic logic is_zero(input logic [DLFP_MAXW-1:0] x, input int ew, input int mw);
    logic r;
    r = 1'b1;
    for (int i = 0; i < DLFP_MAXW; i++)
      if (i >= mw && i < mw + ew && x[i]) r = 1'b0;
    return r;
  endfunction

  // Largest finite magnitude: all-ones exponent, all-ones fraction minus one.
  function automatic logic [DLFP_MAXW-1:0] max_finite(input logic sign, input int ew, input int mw);
    logic [DLFP_MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < DLFP_MAXW; i++) begin
      if (i >= 1 && i < ew + mw) r[i] = 1'b1;
      else if (i == ew + mw)     r[i] = sign;
    end
    return r;
  endfunction

endpackage

// File: rtl/dlfp_mul_pipe_if.sv
// Operand/result handshake bundle for the DLfloat multiplier.
interface dlfp_mul_pipe_if #(
  parameter int EW = 6,
  parameter int MW = 9
);
  import dlfp_pkg::*;

  localparam int W = 1 + EW + MW;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  dlfp_flags_t  out_flags;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );

endinterface

// File: rtl/dlfp_round_norm.sv
// Normalise a raw mantissa product, round to nearest even, and classify the
// result (special/zero/underflow/overflow). Purely combinational.
module dlfp_round_norm
  import dlfp_pkg::*;
#(
  parameter int EW = 6,
  parameter int MW = 9
) (
  input  logic              sign,
  input  logic [EW+1:0]     exp,      // biased exponent, two's complement
  input  logic [2*MW+1:0]   prod,     // {1,fa}*{1,fb}, binary point at bit 2*MW
  input  logic              special,
  input  logic              zero,
  output logic [EW+MW:0]    data,
  output dlfp_flags_t       flags
);

  localparam int EXW  = EW + 2;
  localparam int EMAX = 2**EW - 1;

  logic                  hi, g, st, up, carry;
  logic [MW-1:0]         frac_t, frac_r;
  logic signed [EXW-1:0] e_r;

  // Normalise, round, then pick the result by priority
  always_comb begin
    hi = prod[2*MW+1];
    if (hi) begin
      frac_t = prod[2*MW:MW+1];
      g      = prod[MW];
      st     = |prod[MW-1:0];
    end else begin
      frac_t = prod[2*MW-1:MW];
      g      = prod[MW-1];
      st     = |prod[MW-2:0];
    end
    up = g & (st | frac_t[0]);
    {carry, frac_r} = {1'b0, frac_t} + (MW+1)'(up);
    // A rounding carry leaves frac_r all zero, so only the exponent moves.
    e_r = $signed(exp + EXW'(hi) + EXW'(carry));

    data  = '0;
    flags = '0;
    if (special) begin
      data      = '1;
      flags.inv = 1'b1;
    end else if (zero) begin
      data = '0;
    end else if (e_r < $signed(EXW'(1))) begin
      flags.unf  = 1'b1;
      flags.inex = 1'b1;
    end else if (e_r > $signed(EXW'(EMAX)) ||
                 (e_r == $signed(EXW'(EMAX)) && &frac_r)) begin
      // The all-ones pattern is reserved for NaN/Inf, so saturate one below it.
      data       = (EW+MW+1)'(max_finite(sign, EW, MW));
      flags.ovf  = 1'b1;
      flags.inex = 1'b1;
    end else begin
      data       = {sign, e_r[EW-1:0], frac_r};
      flags.inex = g | st;
    end
  end

endmodule

// File: rtl/dlfp_mul_pipe.sv
// Pipelined DLfloat multiplier with valid/ready on both sides. Registers sit
// after unpack and after multiply; any further stages are output-side retiming.
module dlfp_mul_pipe
  import dlfp_pkg::*;
#(
  parameter int EW     = 6,
  parameter int MW     = 9,
  parameter int BIAS   = 2**(EW-1) - 1,
  parameter int STAGES = 3
) (
  input logic             clk,
  input logic             rst_n,
  dlfp_mul_pipe_if.slave  bus
);

  localparam int W   = 1 + EW + MW;
  localparam int PW  = 2*MW + 2;
  localparam int EXW = EW + 2;
  localparam int NR  = (STAGES >= 3) ? STAGES - 2 : 1;   // result-side registers

  typedef struct packed {
    logic           sign;
    logic [EXW-1:0] exp;
    logic [MW:0]    ma;
    logic [MW:0]    mb;
    logic           special;
    logic           zero;
  } s1_t;

  typedef struct packed {
    logic           sign;
    logic [EXW-1:0] exp;
    logic [PW-1:0]  prod;
    logic           special;
    logic           zero;
  } s2_t;

  typedef struct packed {
    logic [W-1:0] data;
    dlfp_flags_t  flags;
  } res_t;

  logic          adv;
  logic [STAGES:1] vld_pipe;
  s1_t           s1_c, s1_q;
  s2_t           s2_c, s2_q;
  logic [W-1:0]  r_data;
  dlfp_flags_t   r_flags;
  res_t [NR:1]   res_pipe;

  // Whole pipe advances together whenever the output slot is free or draining.
  assign adv          = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;

  // Unpack: sign, unbiased-sum exponent, hidden-one mantissas, encoding class
  always_comb begin
    s1_c.sign    = bus.in_a[W-1] ^ bus.in_b[W-1];
    s1_c.exp     = EXW'(bus.in_a[W-2:MW]) + EXW'(bus.in_b[W-2:MW]) - EXW'(BIAS);
    s1_c.ma      = {1'b1, bus.in_a[MW-1:0]};
    s1_c.mb      = {1'b1, bus.in_b[MW-1:0]};
    s1_c.special = is_special(DLFP_MAXW'(bus.in_a), EW, MW) |
                   is_special(DLFP_MAXW'(bus.in_b), EW, MW);
    s1_c.zero    = is_zero(DLFP_MAXW'(bus.in_a), EW, MW) |
                   is_zero(DLFP_MAXW'(bus.in_b), EW, MW);
  end

  generate
    if (STAGES >= 3) begin : g_s1_reg
      // Unpack result register
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)   s1_q <= '0;
        else if (adv) s1_q <= s1_c;
    end else begin : g_s1_thru
      assign s1_q = s1_c;
    end
  endgenerate

  // Mantissa multiply, side fields carried along
  always_comb begin
    s2_c.sign    = s1_q.sign;
    s2_c.exp     = s1_q.exp;
    s2_c.prod    = PW'(s1_q.ma) * PW'(s1_q.mb);
    s2_c.special = s1_q.special;
    s2_c.zero    = s1_q.zero;
  end

  generate
    if (STAGES >= 2) begin : g_s2_reg
      // Product register
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)   s2_q <= '0;
        else if (adv) s2_q <= s2_c;
    end else begin : g_s2_thru
      assign s2_q = s2_c;
    end
  endgenerate

  dlfp_round_norm #(.EW(EW), .MW(MW)) u_round_norm (
    .sign    (s2_q.sign),
    .exp     (s2_q.exp),
    .prod    (s2_q.prod),
    .special (s2_q.special),
    .zero    (s2_q.zero),
    .data    (r_data),
    .flags   (r_flags)
  );

  // Valid shift register; bubbles travel as zeros
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld_pipe <= '0;
    else if (adv) begin
      vld_pipe[1] <= bus.in_valid;
      for (int j = 2; j <= STAGES; j++) vld_pipe[j] <= vld_pipe[j-1];
    end

  // Result register chain; the last entry drives the output port
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) res_pipe <= '0;
    else if (adv) begin
      res_pipe[1] <= '{data: r_data, flags: r_flags};
      for (int j = 2; j <= NR; j++) res_pipe[j] <= res_pipe[j-1];
    end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_data  = res_pipe[NR].data;
  assign bus.out_flags = res_pipe[NR].flags;

endmodule
